// File: rtl/barrel_shifter32_if.sv
// barrel_shifter32_if
//   Bundles the shifter's operand/amount inputs and its two registered results.
//   Signals:
//     D_left  [31:0]  operand for the left shift
//     D_right [31:0]  operand for the right shift
//     S       [4:0]   shift amount shared by both paths
//     Y_left  [31:0]  registered D_left << S
//     Y_right [31:0]  registered D_right >> S (logical)
//   Modports:
//     master  drives operands and amount, observes results (ALU side / bench)
//     slave   the shifter itself
interface barrel_shifter32_if;
  logic [31:0] D_left;
  logic [31:0] D_right;
  logic [4:0]  S;
  logic [31:0] Y_left;
  logic [31:0] Y_right;

  modport master (output D_left, output D_right, output S,
                  input  Y_left, input  Y_right);
  modport slave  (input  D_left, input  D_right, input  S,
                  output Y_left, output Y_right);
endinterface

// File: rtl/barrel_shifter32.sv
// barrel_shifter32
//   Registered 32-bit logical barrel shifter pair. A left and a right log
//   shifter share one 5-bit amount; stage k shifts by 2^k when S[k] is set.
//   Both results are loaded into output registers every rising CLK edge
//   (1-cycle latency, no enable).
//   Ports:
//     CLK  in   system clock
//     RST  in   synchronous active-low reset; clears both results
//     bus  slave modport of barrel_shifter32_if (D_left, D_right, S in;
//          Y_left, Y_right out)

// One mux stage of a log shifter: passes d through, or shifts it by SH with
// zero fill in the selected direction.
module bs_stage #(
  parameter int W    = 32,
  parameter int SH   = 1,
  parameter bit LEFT = 1'b1
) (
  input  logic         sel,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] shifted;

  if (LEFT) begin : g_left
    assign shifted = {d[W-1-SH:0], {SH{1'b0}}};
  end else begin : g_right
    assign shifted = {{SH{1'b0}}, d[W-1:SH]};
  end

  assign q = sel ? shifted : d;
endmodule

module barrel_shifter32 (
  input  logic               CLK,
  input  logic               RST,
  barrel_shifter32_if.slave  bus
);
  localparam int W      = 32;
  localparam int STAGES = 5;

  // Tap k is the operand after stages 0..k-1; tap STAGES is the final result.
  logic [STAGES:0][W-1:0] l_tap;
  logic [STAGES:0][W-1:0] r_tap;

  assign l_tap[0] = bus.D_left;
  assign r_tap[0] = bus.D_right;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    bs_stage #(.W(W), .SH(1 << k), .LEFT(1'b1)) u_l (
      .sel (bus.S[k]),
      .d   (l_tap[k]),
      .q   (l_tap[k+1])
    );
    bs_stage #(.W(W), .SH(1 << k), .LEFT(1'b0)) u_r (
      .sel (bus.S[k]),
      .d   (r_tap[k]),
      .q   (r_tap[k+1])
    );
  end

  logic [W-1:0] y_left_q;
  logic [W-1:0] y_right_q;

  // Reset is checked first so X on the data path can never leak through a
  // reset edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      y_left_q  <= '0;
      y_right_q <= '0;
    end else begin
      y_left_q  <= l_tap[STAGES];
      y_right_q <= r_tap[STAGES];
    end
  end

  assign bus.Y_left  = y_left_q;
  assign bus.Y_right = y_right_q;
endmodule

// File: tb/tb_barrel_shifter32.sv
module tb_barrel_shifter32;
  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  barrel_shifter32_if bus ();

  barrel_shifter32 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply inputs away from the active edge, clock once, sample 1 time unit after.
  task automatic apply(input logic rst, input logic [31:0] dl,
                       input logic [31:0] dr, input logic [4:0] s);
    @(negedge CLK);
    RST         = rst;
    bus.D_left  = dl;
    bus.D_right = dr;
    bus.S       = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h3);
      n_checks++;
      if (bus.Y_left !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_left edge %0d: got %h expected %h", i, bus.Y_left, 32'h0);
      end
      n_checks++;
      if (bus.Y_right !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_right edge %0d: got %h expected %h", i, bus.Y_right, 32'h0);
      end
    end
  endtask

  task automatic test_walking;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    exp_l = 32'h0000_0001;
    exp_r = 32'h8000_0000;
    for (int s = 0; s < 32; s++) begin
      apply(1'b1, 32'h0000_0001, 32'h8000_0000, 5'(s));
      n_checks++;
      if (bus.Y_left !== exp_l) begin
        n_fail++;
        $display("FAIL walk_left S=%0d: got %h expected %h", s, bus.Y_left, exp_l);
      end
      n_checks++;
      if (bus.Y_right !== exp_r) begin
        n_fail++;
        $display("FAIL walk_right S=%0d: got %h expected %h", s, bus.Y_right, exp_r);
      end
      exp_l = {exp_l[30:0], 1'b0};
      exp_r = {1'b0, exp_r[31:1]};
    end
    // Explicit S=31 endpoint values from the last iteration.
    n_checks++;
    if (bus.Y_left !== 32'h8000_0000 || bus.Y_right !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL walk_s31: got %h/%h expected 80000000/00000001", bus.Y_left, bus.Y_right);
    end
  endtask

  task automatic test_zero_fill;
    apply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h4);
    n_checks++;
    if (bus.Y_left !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL zero_fill_left: got %h expected FFFFFFF0", bus.Y_left);
    end
    n_checks++;
    if (bus.Y_right !== 32'h0FFF_FFFF) begin
      n_fail++;
      $display("FAIL zero_fill_right: got %h expected 0FFFFFFF", bus.Y_right);
    end
  endtask

  task automatic test_pattern;
    apply(1'b1, 32'hA5A5_1234, 32'hA5A5_1234, 5'h0);
    n_checks++;
    if (bus.Y_left !== 32'hA5A5_1234 || bus.Y_right !== 32'hA5A5_1234) begin
      n_fail++;
      $display("FAIL identity: got %h/%h expected A5A51234/A5A51234", bus.Y_left, bus.Y_right);
    end
    apply(1'b1, 32'hA5A5_1234, 32'hA5A5_1234, 5'h10);
    n_checks++;
    if (bus.Y_left !== 32'h1234_0000) begin
      n_fail++;
      $display("FAIL pattern_left: got %h expected 12340000", bus.Y_left);
    end
    n_checks++;
    if (bus.Y_right !== 32'h0000_A5A5) begin
      n_fail++;
      $display("FAIL pattern_right: got %h expected 0000A5A5", bus.Y_right);
    end
    // Independent paths: different operands, mid-range amount.
    apply(1'b1, 32'h0000_00FF, 32'hF000_000F, 5'h7);
    n_checks++;
    if (bus.Y_left !== 32'h0000_7F80 || bus.Y_right !== 32'h01E0_0000) begin
      n_fail++;
      $display("FAIL independent: got %h/%h expected 00007F80/01E00000", bus.Y_left, bus.Y_right);
    end
  endtask

  task automatic test_back_to_back;
    // Each row: rst, D_left, D_right, S, expected Y_left, expected Y_right
    logic [31:0] dl [8];
    logic [31:0] dr [8];
    logic [4:0]  sv [8];
    logic        rv [8];
    logic [31:0] el [8];
    logic [31:0] er [8];
    logic [31:0] prev_l;
    logic [31:0] prev_r;
    dl = '{32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D,
           32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0001, 32'h0F0F_0F0F};
    dr = '{32'h8765_4321, 32'h8765_4321, 32'h0BAD_F00D, 32'h1357_9BDF,
           32'hFFFF_FFFF, 32'hC000_0000, 32'h8000_0001, 32'hF0F0_F0F0};
    sv = '{5'd1, 5'd8, 5'd3, 5'd31, 5'd2, 5'd30, 5'd1, 5'd4};
    rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    el = '{32'h2468_ACF0, 32'h3456_7800, 32'hF56D_F778, 32'h0000_0000,
           32'hFFFF_FFFC, 32'hC000_0000, 32'h0000_0002, 32'hF0F0_F0F0};
    er = '{32'h43B2_A190, 32'h0087_6543, 32'h0175_BE01, 32'h0000_0000,
           32'h3FFF_FFFF, 32'h0000_0003, 32'h4000_0000, 32'h0F0F_0F0F};
    for (int i = 0; i < 8; i++) begin
      apply(rv[i], dl[i], dr[i], sv[i]);
      n_checks++;
      if (bus.Y_left !== el[i] || bus.Y_right !== er[i]) begin
        n_fail++;
        $display("FAIL b2b row %0d: got %h/%h expected %h/%h",
                 i, bus.Y_left, bus.Y_right, el[i], er[i]);
      end
    end
    // Outputs must hold between edges even when inputs change (no comb path).
    prev_l = bus.Y_left;
    prev_r = bus.Y_right;
    bus.D_left  = 32'h5555_5555;
    bus.D_right = 32'hAAAA_AAAA;
    bus.S       = 5'd9;
    #2;
    n_checks++;
    if (bus.Y_left !== 32'hF0F0_F0F0 || bus.Y_right !== 32'h0F0F_0F0F) begin
      n_fail++;
      $display("FAIL hold: got %h/%h expected F0F0F0F0/0F0F0F0F", bus.Y_left, bus.Y_right);
    end
    // Asynchronous RST pulse between edges has no effect.
    RST = 1'b0;
    #1;
    RST = 1'b1;
    #1;
    n_checks++;
    if (bus.Y_left !== prev_l || bus.Y_right !== 32'h0F0F_0F0F) begin
      n_fail++;
      $display("FAIL async_rst: got %h/%h expected F0F0F0F0/0F0F0F0F", bus.Y_left, bus.Y_right);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.Y_left !== 32'hAAAA_AA00 || bus.Y_right !== 32'h0055_5555) begin
      n_fail++;
      $display("FAIL after_pulse: got %h/%h expected AAAAAA00/00555555", bus.Y_left, bus.Y_right);
    end
  endtask

  task automatic test_random;
    logic [31:0] dl;
    logic [31:0] dr;
    logic [4:0]  s;
    logic [31:0] el;
    logic [31:0] er;
    int          errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      dl = $urandom;
      dr = $urandom;
      s  = 5'($urandom_range(0, 31));
      el = dl << s;
      er = dr >> s;
      apply(1'b1, dl, dr, s);
      n_checks++;
      if (bus.Y_left !== el || bus.Y_right !== er) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random %0d S=%0d: got %h/%h expected %h/%h",
                   i, s, bus.Y_left, bus.Y_right, el, er);
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    RST         = 1'b0;
    bus.D_left  = '0;
    bus.D_right = '0;
    bus.S       = '0;
    test_reset();
    test_walking();
    test_zero_fill();
    test_pattern();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
